// File: rtl/newhope_pkg.sv
// newhope_pkg: constants, state type and bit-index helper shared by the
// NewHope message encoder blocks.
package newhope_pkg;

  localparam int NEWHOPE_Q      = 12289;
  localparam int NEWHOPE_HALF_Q = 6144;

  localparam int MSG_BITS  = 256;
  localparam int MSG_WORDS = 8;

  localparam logic [7:0] MSG_LAST_BIT  = 8'(MSG_BITS - 1);
  localparam logic [2:0] MSG_LAST_WORD = 3'(MSG_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2
  } enc_state_e;

  // Position inside a 32-bit message word of message bit b (low five bits):
  // byte k = b[4:3], bit j = b[2:0] LSB-first, stored at index 8k + 7 - j.
  function automatic logic [4:0] msg_bit_index(input logic [4:0] b_lo);
    return {b_lo[4:3], ~b_lo[2:0]};
  endfunction

endpackage

// File: rtl/msg_word_buf.sv
// msg_word_buf: holds the message word being encoded and selects one bit.
// On a capture cycle the incoming word is used directly so the first bit of
// a word is available in the same cycle the word is loaded.
module msg_word_buf
  import newhope_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_i,
  input  logic [0:31] word_i,
  input  logic [4:0]  bit_idx_i,
  output logic        bit_o
);

  logic [0:31] word_q;
  logic [4:0]  idx_s;

  assign idx_s = msg_bit_index(bit_idx_i);

  // Word register: reload on the first write of each message word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q <= '0;
    end else if (capture_i) begin
      word_q <= word_i;
    end else begin
      word_q <= word_q;
    end
  end

  // Bit select: bypass the register while it is being loaded.
  always_comb begin
    bit_o = 1'b0;
    if (capture_i) begin
      bit_o = word_i[idx_s];
    end else begin
      bit_o = word_q[idx_s];
    end
  end

endmodule

// File: rtl/poly_msg_encoder.sv
// poly_msg_encoder: expands a 256-bit message into N/256 copies of a
// polynomial (HALF_Q per 1 bit, 0 per 0 bit), one copy pair per cycle through
// the two polynomial RAM write ports. Message words are prefetched so there
// are no stalls at word boundaries.
// Optional feature: define POLY_ENC_ABORT_EN to add the 'abort' input.
module poly_msg_encoder
  import newhope_pkg::*;
#(
  parameter int N      = 512,
  parameter int COEF_W = 16,
  parameter int HALF_Q = NEWHOPE_HALF_Q,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [2:0]        byte_addr,
  input  logic [0:31]       byte_do,
  output logic              poly_wea,
  output logic              poly_web,
  output logic [ADDR_W-1:0] poly_addra,
  output logic [ADDR_W-1:0] poly_addrb,
  output logic [COEF_W-1:0] poly_dia,
  output logic [COEF_W-1:0] poly_dib
`ifdef POLY_ENC_ABORT_EN
  ,
  input  logic              abort
`endif
);

  // Pair counter reaches this value on the last copy pair of a bit.
  localparam logic [0:0] LAST_PAIR = 1'(N / 512 - 1);

  enc_state_e        state_q;
  logic [7:0]        bit_q;
  logic [0:0]        pair_q;
  logic              busy_q;
  logic              done_q;
  logic              we_q;
  logic [2:0]        byte_addr_q;
  logic [ADDR_W-1:0] addra_q;
  logic [ADDR_W-1:0] addrb_q;
  logic [COEF_W-1:0] data_q;

  logic              active_s;
  logic              capture_s;
  logic              msg_bit_s;
  logic              last_pair_s;
  logic              abort_s;
  logic [2:0]        next_word_s;
  logic [ADDR_W-1:0] addra_s;
  logic [ADDR_W-1:0] addrb_s;
  logic [COEF_W-1:0] data_s;

`ifdef POLY_ENC_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign active_s    = (state_q == FETCH) || (state_q == RUN);
  assign capture_s   = active_s && (bit_q[4:0] == 5'd0) && (pair_q == 1'b0);
  assign last_pair_s = (pair_q == LAST_PAIR);
  // Copy 2c sits at b + 512c, copy 2c+1 at b + 512c + 256.
  assign addra_s     = ADDR_W'({pair_q, 1'b0, bit_q});
  assign addrb_s     = ADDR_W'({pair_q, 1'b1, bit_q});

  msg_word_buf u_word_buf (
    .clk       (clk),
    .rst       (rst),
    .capture_i (capture_s),
    .word_i    (byte_do),
    .bit_idx_i (bit_q[4:0]),
    .bit_o     (msg_bit_s)
  );

  // Coefficient value and the prefetch address of the following word.
  always_comb begin
    data_s      = '0;
    next_word_s = MSG_LAST_WORD;
    if (msg_bit_s) begin
      data_s = COEF_W'(HALF_Q);
    end else begin
      data_s = '0;
    end
    if (bit_q[7:5] == MSG_LAST_WORD) begin
      next_word_s = MSG_LAST_WORD;
    end else begin
      next_word_s = bit_q[7:5] + 3'd1;
    end
  end

  // Job FSM, bit/pair counters and registered write port outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_q       <= 8'd0;
      pair_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      byte_addr_q <= 3'd0;
      addra_q     <= '0;
      addrb_q     <= '0;
      data_q      <= '0;
    end else begin
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addra_q <= '0;
      addrb_q <= '0;
      data_q  <= '0;
      case (state_q)
        IDLE: begin
          byte_addr_q <= 3'd0;
          bit_q       <= 8'd0;
          pair_q      <= 1'b0;
          // The done cycle is still part of the previous job.
          if (start && !done_q) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        FETCH, RUN: begin
          if (abort_s) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            byte_addr_q <= 3'd0;
            bit_q       <= 8'd0;
            pair_q      <= 1'b0;
          end else begin
            we_q    <= 1'b1;
            addra_q <= addra_s;
            addrb_q <= addrb_s;
            data_q  <= data_s;
            if (capture_s) begin
              byte_addr_q <= next_word_s;
            end else begin
              byte_addr_q <= byte_addr_q;
            end
            if (!last_pair_s) begin
              pair_q  <= pair_q + 1'b1;
              state_q <= RUN;
            end else if (bit_q == MSG_LAST_BIT) begin
              pair_q      <= 1'b0;
              bit_q       <= 8'd0;
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              byte_addr_q <= 3'd0;
            end else begin
              pair_q  <= 1'b0;
              bit_q   <= bit_q + 8'd1;
              state_q <= RUN;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign byte_addr  = byte_addr_q;
  assign poly_wea   = we_q;
  assign poly_web   = we_q;
  assign poly_addra = addra_q;
  assign poly_addrb = addrb_q;
  assign poly_dia   = data_q;
  assign poly_dib   = data_q;

endmodule

// File: tb/tb_poly_msg_encoder.sv
// tb_poly_msg_encoder: drives an N=512 and an N=1024 encoder with the same
// stimulus and checks both every cycle against a job-timeline model.
`timescale 1ns/1ps
module tb_poly_msg_encoder;

  localparam int COEF_W = 16;
  localparam int HALF_Q = 6144;

  logic clk = 1'b0;
  logic rst, start, abort_tb;
  logic [0:31] mem [8];
  logic [0:31] do0, do1;

  logic busy0, done0, wea0, web0, busy1, done1, wea1, web1;
  logic [2:0] ba0, ba1;
  logic [8:0] aa0, ab0;
  logic [9:0] aa1, ab1;
  logic [15:0] da0, db0, da1, db1;

  logic busy_v [2], done_v [2], wea_v [2], web_v [2];
  logic [9:0] aa_v [2], ab_v [2];
  logic [15:0] da_v [2], db_v [2];

  int vectors = 0, miscompares = 0, cyc = 0;
  int k_m [2];
  int wr_cnt [2], hot_cnt [2], done_cnt [2], done_cyc [2];
  int hot0_q [$], hot1_q [$];

  always #5 clk = ~clk;

  poly_msg_encoder #(.N(512), .COEF_W(COEF_W), .HALF_Q(HALF_Q)) dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .byte_addr(ba0), .byte_do(do0), .poly_wea(wea0), .poly_web(web0),
    .poly_addra(aa0), .poly_addrb(ab0), .poly_dia(da0), .poly_dib(db0)
`ifdef POLY_ENC_ABORT_EN
    , .abort(abort_tb)
`endif
  );

  poly_msg_encoder #(.N(1024), .COEF_W(COEF_W), .HALF_Q(HALF_Q)) dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .byte_addr(ba1), .byte_do(do1), .poly_wea(wea1), .poly_web(web1),
    .poly_addra(aa1), .poly_addrb(ab1), .poly_dia(da1), .poly_dib(db1)
`ifdef POLY_ENC_ABORT_EN
    , .abort(abort_tb)
`endif
  );

  // Message RAMs: synchronous read, data one cycle after the address.
  always @(posedge clk) begin
    do0 <= mem[ba0];
    do1 <= mem[ba1];
  end

  assign busy_v[0] = busy0; assign busy_v[1] = busy1;
  assign done_v[0] = done0; assign done_v[1] = done1;
  assign wea_v[0]  = wea0;  assign wea_v[1]  = wea1;
  assign web_v[0]  = web0;  assign web_v[1]  = web1;
  assign aa_v[0]   = {1'b0, aa0}; assign aa_v[1] = aa1;
  assign ab_v[0]   = {1'b0, ab0}; assign ab_v[1] = ab1;
  assign da_v[0]   = da0;   assign da_v[1]   = da1;
  assign db_v[0]   = db0;   assign db_v[1]   = db1;

  function automatic int wlen(input int d);
    return (d == 0) ? 256 : 512;
  endfunction

  function automatic int pairs(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // Message bit b: word b/32, byte (b%32)/8, LSB-first bit b%8 at index 8k+7-j.
  function automatic logic msg_bit(input int b);
    logic [0:31] w;
    w = mem[b / 32];
    return w[8 * ((b % 32) / 8) + 7 - (b % 8)];
  endfunction

  // Every-cycle compare against the job timeline, then advance the model.
  // k = cycles since start was sampled: 1 fetch, 2..W+1 writes, W+1 done.
  initial begin
    int k, w, p, n, bb, cc;
    logic ewr, ebusy, edone, ok;
    logic [9:0] ea, eb;
    logic [15:0] ed;
    k_m[0] = -1; k_m[1] = -1;
    for (int d = 0; d < 2; d++) begin
      wr_cnt[d] = 0; hot_cnt[d] = 0; done_cnt[d] = 0; done_cyc[d] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        k = k_m[d]; w = wlen(d); p = pairs(d);
        ebusy = (k >= 1) && (k <= w);
        ewr   = (k >= 2) && (k <= w + 1);
        edone = (k == w + 1);
        ea = '0; eb = '0; ed = '0;
        if (ewr) begin
          n  = k - 2;
          bb = n / p;
          cc = n % p;
          ea = 10'(bb + 512 * cc);
          eb = 10'(bb + 512 * cc + 256);
          ed = msg_bit(bb) ? 16'(HALF_Q) : 16'd0;
        end
        ok = (busy_v[d] === ebusy) && (done_v[d] === edone) &&
             (wea_v[d] === ewr) && (web_v[d] === ewr);
        if (ewr) ok = ok && (aa_v[d] === ea) && (ab_v[d] === eb) &&
                      (da_v[d] === ed) && (db_v[d] === ed);
        vectors++;
        if (!ok) begin
          miscompares++;
          $display("FAIL cycle dut%0d cyc=%0d k=%0d: got busy=%b done=%b we=%b/%b a=%0d b=%0d d=%0d/%0d, want busy=%b done=%b we=%b a=%0d b=%0d d=%0d",
                   d, cyc, k, busy_v[d], done_v[d], wea_v[d], web_v[d], aa_v[d], ab_v[d],
                   da_v[d], db_v[d], ebusy, edone, ewr, ea, eb, ed);
        end
        if (wea_v[d] === 1'b1) begin
          wr_cnt[d]++;
          if (da_v[d] === 16'(HALF_Q)) begin
            hot_cnt[d]++;
            if (d == 0) hot0_q.push_back(int'(aa_v[d]) * 1024 + int'(ab_v[d]));
            else        hot1_q.push_back(int'(aa_v[d]) * 1024 + int'(ab_v[d]));
          end
        end
        if (done_v[d] === 1'b1) begin
          done_cnt[d]++;
          done_cyc[d] = cyc;
        end
        if (rst !== 1'b1)              k_m[d] = -1;
        else if (k == -1)              k_m[d] = (start === 1'b1) ? 1 : -1;
        else if (k == w + 1)           k_m[d] = -1;
        else if (abort_tb === 1'b1)    k_m[d] = -1;
        else                           k_m[d] = k + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int outs_nonzero(input int d);
    return ({busy_v[d], done_v[d], wea_v[d], web_v[d], aa_v[d], ab_v[d], da_v[d], db_v[d]} === '0) ? 0 : 1;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(k_m[0] == -1 && k_m[1] == -1) && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle", (k_m[0] == -1 && k_m[1] == -1) ? 1 : 0, 1);
  endtask

  task automatic wait_writes(input int d, input int base, input int target);
    int n;
    n = 0;
    while ((wr_cnt[d] - base) < target && n < 1000) begin
      tick();
      n++;
    end
    check("wait_writes", ((wr_cnt[d] - base) >= target) ? 1 : 0, 1);
  endtask

  task automatic run_job(output int t0);
    t0 = cyc + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(700);
  endtask

  initial begin
    int t0, wb0, wb1, db0, db1, hb0, hb1;
    rst = 1'b0; start = 1'b0; abort_tb = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outs_dut0", outs_nonzero(0), 0);
    check("reset_outs_dut1", outs_nonzero(1), 0);
    check("reset_byte_addr0", int'(ba0), 0);
    check("reset_byte_addr1", int'(ba1), 0);
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // All ones: every coefficient HALF_Q, done W+1 cycles after start.
    for (int i = 0; i < 8; i++) mem[i] = 32'hFFFF_FFFF;
    wb0 = wr_cnt[0]; wb1 = wr_cnt[1]; hb0 = hot_cnt[0]; hb1 = hot_cnt[1];
    db0 = done_cnt[0]; db1 = done_cnt[1];
    run_job(t0);
    check("ones_writes512", wr_cnt[0] - wb0, 256);
    check("ones_writes1024", wr_cnt[1] - wb1, 512);
    check("ones_hot512", hot_cnt[0] - hb0, 256);
    check("ones_hot1024", hot_cnt[1] - hb1, 512);
    check("ones_done512", done_cnt[0] - db0, 1);
    check("ones_donecyc512", done_cyc[0] - t0, 257);
    check("ones_donecyc1024", done_cyc[1] - t0, 513);

    // Byte 0 = 0x01: only message bit 0 set.
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    mem[0] = 32'h0100_0000;
    tick();
    hb0 = hot0_q.size(); hb1 = hot1_q.size();
    run_job(t0);
    check("lsb_hot512", hot0_q.size() - hb0, 1);
    check("lsb_addr512", hot0_q[hb0], 0 * 1024 + 256);
    check("lsb_hot1024", hot1_q.size() - hb1, 2);
    check("lsb_addr1024_c1", hot1_q[hb1 + 1], 512 * 1024 + 768);

    // Word 7 = 0x80000000: message bit 231.
    mem[0] = 32'h0;
    mem[7] = 32'h8000_0000;
    tick();
    hb0 = hot0_q.size(); hb1 = hot1_q.size(); wb1 = wr_cnt[1];
    run_job(t0);
    check("w7_hot512", hot0_q.size() - hb0, 1);
    check("w7_addr512", hot0_q[hb0], 231 * 1024 + 487);
    check("w7_hot1024", hot1_q.size() - hb1, 2);
    check("w7_addr1024_c0", hot1_q[hb1], 231 * 1024 + 487);
    check("w7_addr1024_c1", hot1_q[hb1 + 1], 743 * 1024 + 999);
    check("w7_writes1024", wr_cnt[1] - wb1, 512);
    check("w7_donecyc1024", done_cyc[1] - t0, 513);

    // Back-to-back: start held high for 1100 cycles.
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    tick();
    wb0 = wr_cnt[0]; wb1 = wr_cnt[1]; db0 = done_cnt[0]; db1 = done_cnt[1];
    start = 1'b1;
    repeat (1100) tick();
    start = 1'b0;
    wait_idle(1200);
    check("b2b_jobs512", done_cnt[0] - db0, 5);
    check("b2b_writes512", wr_cnt[0] - wb0, 1280);
    check("b2b_jobs1024", done_cnt[1] - db1, 3);
    check("b2b_writes1024", wr_cnt[1] - wb1, 1536);

    // Reset in the middle of a job.
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    tick();
    wb0 = wr_cnt[0]; db0 = done_cnt[0]; db1 = done_cnt[1];
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_writes(0, wb0, 100);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_outs0", outs_nonzero(0), 0);
    check("midrst_outs1", outs_nonzero(1), 0);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("midrst_nodone512", done_cnt[0] - db0, 0);
    check("midrst_nodone1024", done_cnt[1] - db1, 0);
    wb0 = wr_cnt[0];
    run_job(t0);
    check("midrst_rerun512", wr_cnt[0] - wb0, 256);
    check("midrst_redone512", done_cyc[0] - t0, 257);

`ifdef POLY_ENC_ABORT_EN
    // Abort at write 50, then a full restart.
    tick();
    wb0 = wr_cnt[0]; db0 = done_cnt[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_writes(0, wb0, 50);
    abort_tb = 1'b1;
    tick();
    abort_tb = 1'b0;
    @(negedge clk);
    check("abort_outs0", outs_nonzero(0), 0);
    check("abort_outs1", outs_nonzero(1), 0);
    tick();
    wait_idle(20);
    check("abort_nodone", done_cnt[0] - db0, 0);
    wb0 = wr_cnt[0];
    run_job(t0);
    check("abort_rerun512", wr_cnt[0] - wb0, 256);
    check("abort_redone512", done_cyc[0] - t0, 257);
`endif

    // Random messages with random start pulses, including during RUN.
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
      tick();
      for (int c = 0; c < 1200; c++) begin
        start = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
        tick();
      end
      start = 1'b0;
      wait_idle(700);
      tick();
    end

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/poly_msg_encoder.md
# poly_msg_encoder

Parametrised successor to the NewHope message encoder. It reads a 256-bit message from the 32-bit-word message RAM and writes one polynomial coefficient per (bit, copy): HALF_Q for a 1 bit, 0 for a 0 bit. The output is replicated N/256 times across the polynomial RAM through its two write ports. It sits between the message buffer and the polynomial RAM ahead of the encryption adder. Unlike the earlier fixed-N encoder, it streams one write cycle per bit-pair with word prefetch, supports N = 512 or 1024, and exposes a `busy` handshake.

## Interface
- `N`, 512: polynomial length; legal values 512 and 1024. R = N/256 copies.
- `COEF_W`, 16: coefficient width.
- `HALF_Q`, 6144: value written for a 1 bit. Must fit in COEF_W.
- `ADDR_W`, $clog2(N): derived polynomial address width; not overridden.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-low. The port keeps the codebase name `rst`, but the polarity is active-low.
- `start` in 1: job request, sampled only in IDLE.
- `busy` out 1: high while a job runs.
- `done` out 1: one-cycle pulse, coincident with the last write.
- `byte_addr` out 3: message word address.
- `byte_do` in [0:31]: message word, returned one cycle after `byte_addr`.
- `poly_wea`, `poly_web` out 1: write strobes. They are always equal.
- `poly_addra`, `poly_addrb` out ADDR_W: write addresses.
- `poly_dia`, `poly_dib` out COEF_W: write data. They are always equal.

## Operation
- **Bit mapping.** Message bit b (0..255) is taken from word w = b[7:5], byte k = b[4:3], bit j = b[2:0] (LSB-first within the byte). It lives at `byte_do` index 8k + 7 − j.
- **Copy pairs.** Per bit, pair index c runs over 0..R/2−1:
  - `poly_addra` = b + 256·(2c)
  - `poly_addrb` = b + 256·(2c+1)
  - Data = HALF_Q if the bit is 1, else 0.
- **Write order.** Bits in ascending order; for each bit, all pairs in ascending c before moving to the next bit. Total writes W = 256·R/2 cycles (256 for N=512, 512 for N=1024).
- **States:**
  - IDLE → FETCH on `start`.
  - FETCH presents word 0 for one cycle → RUN.
  - RUN writes one pair per cycle. After the final pair of bit 255 it returns to IDLE.
- **Word prefetch.** A word register captures `byte_do` at the edge that starts the word's first write. During the current word's writes, `byte_addr` holds w+1 (clamped at 7) at least one cycle before the next capture edge. There are no stall cycles at word boundaries.
- **`start` handling.** `start` outside IDLE is ignored. `start` in the cycle after `done` launches a new job normally.
- **Outputs.** All outputs are registered, so strobes, addresses and data change only on `clk` edges.

## Timing
- **Reset.** `rst`=0 at an edge gives state IDLE, counters 0, and all outputs 0: `busy`, `done`, strobes, addresses, data and `byte_addr`.
- **Reset mid-job.** The job is abandoned with no `done` pulse and no further writes from the next cycle.
- **Job timeline.**
  - Cycle 0: `start` sampled.
  - Cycle 1: FETCH; `busy`=1; `byte_addr`=0.
  - Cycles 2..W+1: writes visible on the outputs.
  - Cycle W+1: `done`=1 together with the last write; `busy`=0 in that same cycle.
- **Between jobs.** Write strobes are low in every cycle outside the write window.
- **Back-to-back jobs.** The minimum start-to-start interval is W+2 cycles.

## Configuration
- Macro `POLY_ENC_ABORT_EN`.
- **Defined:** adds input `abort` (1 bit). `abort`=1 in FETCH or RUN returns the block to IDLE at the next edge. No write and no `done` are issued in the following cycle; `busy` is low from then on. `abort` has priority over the write scheduled for that edge.
- **Undefined:** no `abort` port; jobs always run to completion or until reset.

## Structure
- **Shared package `newhope_pkg`:**
  - NEWHOPE_Q = 12289, NEWHOPE_HALF_Q = 6144.
  - MSG_BITS = 256, MSG_WORDS = 8.
  - The encoder state enum (IDLE, FETCH, RUN).
- **Sub-module `msg_word_buf`:** word register plus index-(8k+7−j) bit select, with a capture enable and a bit-index input.
- **Top level:** holds the FSM, the b/c counters, and the output registers.

## Test plan
- **N=512, message all 0xFF.** 256 write cycles. Every `poly_dia` = 6144; addresses a = 0..255 and b = 256..511 in order; `done` on cycle 257 after `start`.
- **N=512, message byte0 = 0x01, rest 0.** Only addresses 0 and 256 get 6144; all others get 0. Confirms LSB-first order and the 8k+7−j index.
- **N=1024, word 7 = 0x80000000, rest 0.** 512 writes. Bit 231 is set (k=0, j=7 → index 0 of word 7), so addresses 231, 487, 743 and 999 each get 6144 on two consecutive cycles (pair c=0, then c=1). `done` on cycle 513.
- **Back-to-back jobs.** `start` held high continuously: the second job starts at cycle W+2 with no lost writes. `start` pulses during RUN are ignored.
- **Reset mid-job.** `rst` pulled low at write 100: outputs are 0 the next cycle, no `done`, and a fresh `start` then completes correctly.
- **Abort (`POLY_ENC_ABORT_EN` defined).** `abort` at write 50: no write and no `done` in the following cycle, `busy` low from then on, and a restart produces the full sequence.
